spi_frame_arb: RTL

SPI_FRAME_ARB -- requirements
Module: spi_frame_arb

---
 rtl/spi_frame_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_arb.sv
// spi_frame_arb: two-client round-robin arbiter that frames byte bursts onto
// a single SPI shifter. It owns chip select (setup, hold and inter-frame gap)
// and hands the granted client's bytes to the shifter, one spi_go per byte.
module spi_frame_arb #(
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       grant0,
  output logic       grant1,
  output logic       rd0,
  output logic       rd1,
  output logic       cs_n,
  output logic       spi_go,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, ARM, SHIFT, HOLD, GAP
  } state_e;

  // Terminal counts; each phase counter starts at 0 on entry.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  // Client inputs gathered into packed arrays so the datapath indexes by client.
  logic [1:0]      req;
  logic [1:0][3:0] len;
  logic [1:0][7:0] data;

  assign req  = {req1, req0};
  assign len  = {len1, len0};
  assign data = {data1, data0};

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;      // phase counter for SETUP / HOLD / GAP
  logic [7:0] cnt_inc;           // saturating increment, never wraps
  logic [4:0] rem_q, rem_d;      // bytes still to send in this frame (1..16)
  logic [1:0] gnt_q, gnt_d;      // one-hot owner of the bus
  logic       prio_q, prio_d;    // client that wins the next tie
  logic       cs_n_q, cs_n_d;
  logic       go_q, go_d;
  logic [1:0] rd_q, rd_d;
  logic [7:0] sdata_q, sdata_d;
  logic       win;               // client chosen in IDLE
  logic       cur;               // client currently granted

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign cur     = gnt_q[1];

  // Next-state and registered-output decode; defaults hold state, pulses low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    cs_n_d  = cs_n_q;
    go_d    = 1'b0;
    rd_d    = 2'b00;
    sdata_d = sdata_q;
    win     = prio_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the favoured client wins; a lone requester always wins.
          win     = (&req) ? prio_q : req[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          prio_d  = ~win;
          rem_d   = {1'b0, len[win]} + 5'd1;
          cnt_d   = 8'd0;
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q >= SETUP_LAST) begin
          cnt_d   = 8'd0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOAD: begin
        // Byte, go and rd are launched together so the client advances its
        // data exactly when the shifter takes the current byte.
        if (spi_done) begin
          go_d    = 1'b1;
          rd_d    = gnt_q;
          sdata_d = data[cur];
          state_d = ARM;
        end
      end
      ARM: begin
        // The shifter still shows idle in this cycle; skip it.
        state_d = SHIFT;
      end
      SHIFT: begin
        if (spi_done) begin
          rem_d = rem_q - 5'd1;
          if (rem_q > 5'd1) begin
            state_d = LOAD;
          end else begin
            cnt_d   = 8'd0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q >= HOLD_LAST) begin
          cnt_d   = 8'd0;
          cs_n_d  = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = 8'd0;
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rem_q   <= 5'd0;
      gnt_q   <= 2'b00;
      prio_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      go_q    <= 1'b0;
      rd_q    <= 2'b00;
      sdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      cs_n_q  <= cs_n_d;
      go_q    <= go_d;
      rd_q    <= rd_d;
      sdata_q <= sdata_d;
    end
  end

  assign grant0   = gnt_q[0];
  assign grant1   = gnt_q[1];
  assign rd0      = rd_q[0];
  assign rd1      = rd_q[1];
  assign cs_n     = cs_n_q;
  assign spi_go   = go_q;
  assign spi_data = sdata_q;
  assign busy     = (state_q != IDLE);

endmodule
